// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-source round-robin mux arbiter:
// source encodings, default widths and the saturating counter helper.
package mux_arb_pkg;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        if (v == max_v)
            return v;
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/mux2_bus.sv
// WIDTH-bit 2:1 data select feeding the arbiter output register.
// Purely combinational; no flow control of its own.
module mux2_bus #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? i1 : i0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink between two requesters, with per-source grant counters.
// Latency: 1 cycle (registered output stage), 1 beat/cycle throughput. Optional lock via MUX_ARB_LOCK_EN.
// Backpressure: while the output register is full and not draining, both requester readys are held at 0.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
`ifdef MUX_ARB_LOCK_EN
    input  logic             in0_lock,
    input  logic             in1_lock,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    logic             prio;
    logic             sel;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] mux_y;

`ifdef MUX_ARB_LOCK_EN
    logic locked;
    logic owner;
    logic lock_sel;
`endif

    assign can_load = ~out_valid | out_ready;

    always_comb begin
        sel = SRC0;
        if (in0_valid & in1_valid)
            sel = prio;
        else if (in1_valid)
            sel = SRC1;
`ifdef MUX_ARB_LOCK_EN
        // A locked owner keeps the grant even when it is momentarily idle.
        if (locked)
            sel = owner;
`endif
    end

    assign in0_ready = ~rst & can_load & (sel == SRC0) & in0_valid;
    assign in1_ready = ~rst & can_load & (sel == SRC1) & in1_valid;
    assign xfer      = in0_ready | in1_ready;

    mux2_bus #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .i0  (in0_data),
        .i1  (in1_data),
        .y   (mux_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC0;
            prio      <= SRC0;
            gnt_cnt0  <= '0;
            gnt_cnt1  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_y;
            out_src   <= sel;
            prio      <= ~sel;
            if (sel == SRC0)
                gnt_cnt0 <= CNT_W'(sat_inc(32'(gnt_cnt0), CNT_W));
            else
                gnt_cnt1 <= CNT_W'(sat_inc(32'(gnt_cnt1), CNT_W));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_ARB_LOCK_EN
    assign lock_sel = sel ? in1_lock : in0_lock;

    // While locked only the owner can transfer, so any unlocking beat is the owner's.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked <= 1'b0;
            owner  <= SRC0;
        end else if (xfer) begin
            if (lock_sel) begin
                locked <= 1'b1;
                owner  <= sel;
            end else begin
                locked <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: reset, single source, alternation, stall, saturation, lock.
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_sat = 1'b1;
    logic       in0_valid = 1'b0;
    logic       in1_valid = 1'b0;
    logic [7:0] in0_data = 8'h00;
    logic [7:0] in1_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       in0_ready, in1_ready, out_valid, out_src;
    logic [7:0] out_data, gnt_cnt0, gnt_cnt1;

    logic       sat_in0_ready, sat_in1_ready, sat_out_valid, sat_out_src;
    logic [7:0] sat_out_data;
    logic [1:0] sat_cnt0, sat_cnt1;

`ifdef MUX_ARB_LOCK_EN
    logic in0_lock = 1'b0;
    logic in1_lock = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
`ifdef MUX_ARB_LOCK_EN
        .in0_lock  (in0_lock),
        .in1_lock  (in1_lock),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
    );

    mux2_rr_arbiter #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst_sat),
        .in0_valid (in0_valid),
        .in0_ready (sat_in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (sat_in1_ready),
        .in1_data  (in1_data),
`ifdef MUX_ARB_LOCK_EN
        .in0_lock  (in0_lock),
        .in1_lock  (in1_lock),
`endif
        .out_valid (sat_out_valid),
        .out_ready (out_ready),
        .out_data  (sat_out_data),
        .out_src   (sat_out_src),
        .gnt_cnt0  (sat_cnt0),
        .gnt_cnt1  (sat_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset: readys must stay low even with both requesters valid.
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_cnt0", 32'(gnt_cnt0), 32'd0);
        chk("rst_cnt1", 32'(gnt_cnt1), 32'd0);
        chk("rst_rdy0", 32'(in0_ready), 32'd0);
        chk("rst_rdy1", 32'(in1_ready), 32'd0);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single requester 0: three beats back to back.
        for (int i = 0; i < 3; i++) begin
            in0_valid = 1'b1;
            in0_data  = 8'(17 * (i + 1));
            #1;
            chk("t2_rdy0", 32'(in0_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("t2_out_valid", 32'(out_valid), 32'd1);
            chk("t2_out_data", 32'(out_data), 32'(17 * (i + 1)));
            chk("t2_out_src", 32'(out_src), 32'd0);
        end
        in0_valid = 1'b0;
        chk("t2_cnt0", 32'(gnt_cnt0), 32'd3);
        @(posedge clk);
        #1;
        chk("t2_drain_valid", 32'(out_valid), 32'd0);
        chk("t2_drain_hold", 32'(out_data), 32'h33);

        // Asynchronous reset between edges with a beat in the output register.
        in0_valid = 1'b1;
        in0_data  = 8'h44;
        @(posedge clk);
        #1;
        chk("t1_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_valid", 32'(out_valid), 32'd0);
        chk("t1_data", 32'(out_data), 32'h00);
        chk("t1_cnt0", 32'(gnt_cnt0), 32'd0);
        chk("t1_rdy0", 32'(in0_ready), 32'd0);
        in0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both valid continuously: strict alternation starting at 0.
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'hA0;
        in1_data  = 8'hB0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t3_rdy0", 32'(in0_ready), 32'(i % 2 == 0));
            chk("t3_rdy1", 32'(in1_ready), 32'(i % 2 == 1));
            @(posedge clk);
            #1;
            chk("t3_src", 32'(out_src), 32'(i % 2));
            chk("t3_data", 32'(out_data), (i % 2 == 1) ? 32'hB0 : 32'hA0);
        end
        chk("t3_cnt0", 32'(gnt_cnt0), 32'd4);
        chk("t3_cnt1", 32'(gnt_cnt1), 32'd4);

        // Stall three cycles: everything held, then grant passes to source 0.
        out_ready = 1'b0;
        in0_data  = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_rdy0", 32'(in0_ready), 32'd0);
            chk("t4_rdy1", 32'(in1_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("t4_valid", 32'(out_valid), 32'd1);
            chk("t4_data", 32'(out_data), 32'hB0);
            chk("t4_src", 32'(out_src), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_rel_rdy0", 32'(in0_ready), 32'd1);
        chk("t4_rel_rdy1", 32'(in1_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t4_rel_src", 32'(out_src), 32'd0);
        chk("t4_rel_data", 32'(out_data), 32'hC0);
        chk("t4_rel_cnt0", 32'(gnt_cnt0), 32'd5);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_drain_valid", 32'(out_valid), 32'd0);
        chk("t4_drain_hold", 32'(out_data), 32'hC0);

        // Saturation on a 2-bit counter instance; the 8-bit one keeps counting.
        rst_sat   = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t5_sat_cnt0", 32'(sat_cnt0), (i < 2) ? 32'(i + 1) : 32'd3);
            chk("t5_cnt0", 32'(gnt_cnt0), 32'(6 + i));
        end
        in0_valid = 1'b0;
        chk("t5_sat_cnt1", 32'(sat_cnt1), 32'd0);

`ifdef MUX_ARB_LOCK_EN
        // Lock: in0 holds the grant for 3 locked beats plus the unlocking beat.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in0_lock = (i < 3);
            #1;
            chk("t6_rdy1", 32'(in1_ready), 32'(i == 4));
            @(posedge clk);
            #1;
            chk("t6_src", 32'(out_src), 32'(i == 4));
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_lock  = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
